// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: counter width, control-bit positions, word type
// and the saturating increment used by the stage latch counters.
package cpu_types_pkg;

  localparam int CNT_W = 16;

  localparam int CTRL_DREN = 0;
  localparam int CTRL_DWEN = 1;
  localparam int CTRL_WEN  = 2;
  localparam int CTRL_WSEL = 3;
  localparam int CTRL_BEQ  = 4;
  localparam int CTRL_BNE  = 5;
  localparam int CTRL_J    = 6;
  localparam int CTRL_JR   = 7;

  typedef logic [31:0]      word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/latch_slot.sv
// One pipeline slot {valid, halt, ctrl, data} with clear, load and hold.
// Clear beats load; reset beats both.
module latch_slot
  import cpu_types_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NCTRL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             valid_i,
  input  logic             halt_i,
  input  logic [NCTRL-1:0] ctrl_i,
  input  logic [DW-1:0]    data_i,
  output logic             valid_o,
  output logic             halt_o,
  output logic [NCTRL-1:0] ctrl_o,
  output logic [DW-1:0]    data_o
);

  logic             valid_q, valid_d;
  logic             halt_q,  halt_d;
  logic [NCTRL-1:0] ctrl_q,  ctrl_d;
  logic [DW-1:0]    data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      halt_d  = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load) begin
      valid_d = valid_i;
      halt_d  = halt_i;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      halt_q  <= halt_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign halt_o  = halt_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stage_latch.sv
// Pipeline stage latch: DEPTH cascaded slots with stall, flush, sticky halt
// and saturating stall/flush cycle counters.
module stage_latch
  import cpu_types_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NCTRL = 16,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [DW-1:0]    data_i,
  input  logic [NCTRL-1:0] ctrl_i,
  input  logic             halt_i,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  output logic [NCTRL-1:0] ctrl_o,
  output logic             halt_o,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  logic [DEPTH-1:0]            s_valid;
  logic [DEPTH-1:0]            s_halt;
  logic [DEPTH-1:0][NCTRL-1:0] s_ctrl;
  logic [DEPTH-1:0][DW-1:0]    s_data;

  logic halt_q, halt_d;
  cnt_t stall_cnt_q, stall_cnt_d;
  cnt_t flush_cnt_q, flush_cnt_d;
  logic advance;

  // A latched halt freezes the chain exactly like a stall.
  assign advance = en & ~halt_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic             in_valid;
    logic             in_halt;
    logic [NCTRL-1:0] in_ctrl;
    logic [DW-1:0]    in_data;

    if (k == 0) begin : g_head
      assign in_valid = valid_i;
      assign in_halt  = halt_i & valid_i;
      assign in_ctrl  = ctrl_i;
      assign in_data  = data_i;
    end else begin : g_body
      assign in_valid = s_valid[k-1];
      assign in_halt  = s_halt[k-1];
      assign in_ctrl  = s_ctrl[k-1];
      assign in_data  = s_data[k-1];
    end

    latch_slot #(.DW(DW), .NCTRL(NCTRL)) u_slot (
      .clk     (CLK),
      .rst     (RST),
      .clr     (flush),
      .load    (advance),
      .valid_i (in_valid),
      .halt_i  (in_halt),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (s_valid[k]),
      .halt_o  (s_halt[k]),
      .ctrl_o  (s_ctrl[k]),
      .data_o  (s_data[k])
    );
  end

  always_comb begin
    halt_d      = halt_q | (s_valid[DEPTH-1] & s_halt[DEPTH-1]);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!en && !flush && !halt_q && (|s_valid))
      stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush)
      flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_o   = s_valid[DEPTH-1];
  assign data_o    = s_data[DEPTH-1];
  // Bubbles must never present write enables downstream.
  assign ctrl_o    = s_valid[DEPTH-1] ? s_ctrl[DEPTH-1] : '0;
  assign halt_o    = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_stage_latch.sv
// Directed bench for stage_latch at DEPTH 1, 2 and 3 with a scoreboard queue.
module tb_stage_latch;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [3];
  logic        en      [3];
  logic        flush   [3];
  logic        valid_i [3];
  word_t       data_i  [3];
  logic [15:0] ctrl_i  [3];
  logic        halt_i  [3];
  logic        valid_o [3];
  word_t       data_o  [3];
  logic [15:0] ctrl_o  [3];
  logic        halt_o  [3];
  logic [15:0] stall_c [3];
  logic [15:0] flush_c [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    stage_latch #(.DW(32), .NCTRL(16), .DEPTH(g + 1)) dut (
      .CLK       (clk),
      .RST       (rst[g]),
      .en        (en[g]),
      .flush     (flush[g]),
      .valid_i   (valid_i[g]),
      .data_i    (data_i[g]),
      .ctrl_i    (ctrl_i[g]),
      .halt_i    (halt_i[g]),
      .valid_o   (valid_o[g]),
      .data_o    (data_o[g]),
      .ctrl_o    (ctrl_o[g]),
      .halt_o    (halt_o[g]),
      .stall_cnt (stall_c[g]),
      .flush_cnt (flush_c[g])
    );
  end

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk({tag, " valid_o"}, 64'(valid_o[u]), 64'd0);
    chk({tag, " data_o"},  64'(data_o[u]),  64'd0);
    chk({tag, " ctrl_o"},  64'(ctrl_o[u]),  64'd0);
    chk({tag, " halt_o"},  64'(halt_o[u]),  64'd0);
    chk({tag, " stall"},   64'(stall_c[u]), 64'd0);
    chk({tag, " flush"},   64'(flush_c[u]), 64'd0);
  endtask

  task automatic pop_chk(input int u, input string tag);
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " valid"}, 64'(valid_o[u]), 64'(e.v));
      chk({tag, " data"},  64'(data_o[u]),  64'(e.d));
      chk({tag, " ctrl"},  64'(ctrl_o[u]),  64'(e.c));
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; en[u] = 1'b0; flush[u] = 1'b0; valid_i[u] = 1'b0;
      data_i[u] = 32'h5555_AAAA; ctrl_i[u] = 16'hFFFF; halt_i[u] = 1'b1;
    end
    step();
    for (int u = 0; u < 3; u++) chk_zero(u, "reset");
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0; halt_i[u] = 1'b0;
    end

    // DEPTH=2 latency
    en[1] = 1'b1; valid_i[1] = 1'b1; data_i[1] = 32'hDEADBEEF; ctrl_i[1] = 16'h0005;
    sb.push_back('{v: 1'b1, d: 32'hDEADBEEF, c: 16'h0005});
    step();
    valid_i[1] = 1'b0; data_i[1] = 32'h0; ctrl_i[1] = 16'h0;
    chk("d2 edge1 valid", 64'(valid_o[1]), 64'd0);
    step();
    pop_chk(1, "d2 edge2");

    // DEPTH=1 streaming with bubbles carrying nonzero ctrl and stray halt
    en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_i[0] = (i % 3 != 1);
      data_i[0]  = $urandom;
      ctrl_i[0]  = 16'($urandom) | 16'h0001;
      halt_i[0]  = !valid_i[0];
      sb.push_back('{v: valid_i[0], d: data_i[0], c: valid_i[0] ? ctrl_i[0] : 16'h0});
      step();
      pop_chk(0, "d1 stream");
    end
    halt_i[0] = 1'b0;
    chk("d1 bubble halt", 64'(halt_o[0]), 64'd0);

    // stall for 3 cycles
    valid_i[0] = 1'b1; data_i[0] = 32'h1234_5678; ctrl_i[0] = 16'h00A3;
    step();
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i[0] = 1'b1; data_i[0] = 32'h9000_0000 + i; ctrl_i[0] = 16'h0F00;
      step();
      chk("d1 stall data", 64'(data_o[0]), 64'h1234_5678);
      chk("d1 stall ctrl", 64'(ctrl_o[0]), 64'h00A3);
    end
    chk("d1 stall_cnt 3", 64'(stall_c[0]), 64'd3);
    en[0] = 1'b1; data_i[0] = 32'hCAFE_F00D; ctrl_i[0] = 16'h0044;
    sb.push_back('{v: 1'b1, d: 32'hCAFE_F00D, c: 16'h0044});
    step();
    pop_chk(0, "d1 resume");

    // flush with en=0 on a valid slot
    en[0] = 1'b0; flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("d1 flush valid", 64'(valid_o[0]), 64'd0);
    chk("d1 flush ctrl",  64'(ctrl_o[0]),  64'd0);
    chk("d1 flush data",  64'(data_o[0]),  64'd0);
    chk("d1 flush_cnt",   64'(flush_c[0]), 64'd1);
    chk("d1 flush stall", 64'(stall_c[0]), 64'd3);

    // stall counter saturation
    en[0] = 1'b1; valid_i[0] = 1'b1;
    step();
    en[0] = 1'b0;
    for (int i = 0; i < 65531; i++) step();
    chk("d1 stall FFFE", 64'(stall_c[0]), 64'hFFFE);
    step();
    step();
    chk("d1 stall FFFF", 64'(stall_c[0]), 64'hFFFF);
    step();
    chk("d1 stall held", 64'(stall_c[0]), 64'hFFFF);

    // DEPTH=3 halt
    en[2] = 1'b1; valid_i[2] = 1'b1; halt_i[2] = 1'b1;
    data_i[2] = 32'hBAAD_F00D; ctrl_i[2] = 16'h0081;
    step();
    valid_i[2] = 1'b0; halt_i[2] = 1'b0; data_i[2] = 32'h0; ctrl_i[2] = 16'h0;
    step();
    step();
    chk("d3 e3 valid", 64'(valid_o[2]), 64'd1);
    chk("d3 e3 data",  64'(data_o[2]),  64'hBAAD_F00D);
    chk("d3 e3 halt",  64'(halt_o[2]),  64'd0);
    en[2] = 1'b0;
    step();
    chk("d3 e4 halt",  64'(halt_o[2]),  64'd1);
    chk("d3 e4 valid", 64'(valid_o[2]), 64'd1);
    chk("d3 e4 stall", 64'(stall_c[2]), 64'd1);
    en[2] = 1'b1; valid_i[2] = 1'b1; data_i[2] = 32'h1111_1111;
    step();
    chk("d3 frozen data", 64'(data_o[2]), 64'hBAAD_F00D);
    chk("d3 frozen ctrl", 64'(ctrl_o[2]), 64'h0081);
    en[2] = 1'b0;
    step();
    chk("d3 halted stall", 64'(stall_c[2]), 64'd1);
    en[2] = 1'b1; flush[2] = 1'b1;
    step();
    flush[2] = 1'b0; en[2] = 1'b0;
    chk("d3 flush valid", 64'(valid_o[2]), 64'd0);
    chk("d3 flush data",  64'(data_o[2]),  64'd0);
    chk("d3 flush ctrl",  64'(ctrl_o[2]),  64'd0);
    chk("d3 flush halt",  64'(halt_o[2]),  64'd1);
    chk("d3 flush_cnt",   64'(flush_c[2]), 64'd1);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    chk_zero(2, "d3 rst_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
